// File: rtl/psum_deskew_collector.sv
// Systolic-array psum drain: per-lane delay lines undo the column skew, then a small FIFO buffers aligned row vectors.
// Optional PSUM_RELU_EN adds a relu_en input that clamps negative lanes to zero on write.

module psum_delay_lane #(
  parameter int DEPTH = 1
) (
  input  logic        clk,
  input  logic        flush,
  input  logic [31:0] psum_in,
  input  logic        valid_in,
  output logic [31:0] psum_out,
  output logic        valid_out
);
  logic [DEPTH-1:0][31:0] d_pipe;
  logic [DEPTH-1:0]       vld_pipe;

  always_ff @(posedge clk) begin
    if (flush) begin
      d_pipe   <= '0;
      vld_pipe <= '0;
    end else begin
      // invalid samples travel as zero so nothing stale can leak into a vector
      d_pipe[0]   <= valid_in ? psum_in : '0;
      vld_pipe[0] <= valid_in;
      for (int i = 1; i < DEPTH; i++) begin
        d_pipe[i]   <= d_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign psum_out  = d_pipe[DEPTH-1];
  assign valid_out = vld_pipe[DEPTH-1];
endmodule

module psum_deskew_collector #(
  parameter int N_COLS     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic [N_COLS*32-1:0]            col_psum_in,
  input  logic [N_COLS-1:0]               col_valid_in,
  output logic [N_COLS*32-1:0]            out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
`ifdef PSUM_RELU_EN
  input  logic                            relu_en,
`endif
  output logic [$clog2(FIFO_DEPTH+1)-1:0] vec_count,
  output logic                            overflow,
  output logic                            skew_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [N_COLS-1:0][31:0] lane_psum, al_psum, wr_data;
  logic [N_COLS-1:0]       al_vld;
  logic                    flush;

  assign lane_psum = col_psum_in;
  assign flush     = rst | clear;

  // lane j waits N_COLS-1-j cycles so all lanes of one vector meet together
  for (genvar j = 0; j < N_COLS; j++) begin : g_lane
    if (j < N_COLS-1) begin : g_dly
      psum_delay_lane #(.DEPTH(N_COLS-1-j)) u_lane (
        .clk      (clk),
        .flush    (flush),
        .psum_in  (lane_psum[j]),
        .valid_in (col_valid_in[j]),
        .psum_out (al_psum[j]),
        .valid_out(al_vld[j])
      );
    end else begin : g_thru
      assign al_psum[j] = col_valid_in[j] ? lane_psum[j] : '0;
      assign al_vld[j]  = col_valid_in[j];
    end
  end

  always_comb begin
    wr_data = al_psum;
`ifdef PSUM_RELU_EN
    for (int j = 0; j < N_COLS; j++)
      if (relu_en && al_psum[j][31]) wr_data[j] = '0;
`endif
  end

  logic [N_COLS-1:0][31:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    push_req, any_vld, full, pop, push;

  assign push_req = &al_vld;
  assign any_vld  = |al_vld;
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = out_valid & out_ready;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign push     = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req & full & ~pop) overflow <= 1'b1;
      if (any_vld & ~push_req)    skew_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && push) mem[wr_ptr] <= wr_data;
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign vec_count = count;
endmodule

// File: tb/tb_psum_deskew_collector.sv
// Bench for psum_deskew_collector: directed table, corner sequences, random traffic vs a queue-based model.
module tb_psum_deskew_collector;
  localparam int N = 4;
  localparam int D = 4;
  localparam int SL = 512;

  logic                   clk = 0;
  logic                   rst, clear, out_ready, out_valid, overflow, skew_err;
  logic [N-1:0][31:0]     col_psum_in, out_data;
  logic [N-1:0]           col_valid_in;
  logic [2:0]             vec_count;
  logic                   relu_en = 0;

  psum_deskew_collector #(.N_COLS(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .col_psum_in(col_psum_in), .col_valid_in(col_valid_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef PSUM_RELU_EN
    .relu_en(relu_en),
`endif
    .vec_count(vec_count), .overflow(overflow), .skew_err(skew_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // model: input history (newest first) and the FIFO as a queue of vectors
  typedef struct { logic [N-1:0] v; logic [N-1:0][31:0] p; } samp_t;
  samp_t              past[$];
  logic [N-1:0][31:0] mq[$];
  bit                 m_ovf, m_skw;

  task automatic check(input string name, input logic [N*32-1:0] act, input logic [N*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [N-1:0][31:0] ed;
    ed = (mq.size() != 0) ? mq[0] : '0;
    check("out_valid", out_valid, mq.size() != 0);
    check("vec_count", vec_count, mq.size());
    check("overflow",  overflow,  m_ovf);
    check("skew_err",  skew_err,  m_skw);
    check("out_data",  out_data,  ed);
  endtask

  task automatic model_update(input logic r, input logic c, input logic [N-1:0] v,
                              input logic [N-1:0][31:0] p, input logic rdy);
    logic [N-1:0] av;
    logic [N-1:0][31:0] ap;
    samp_t s;
    bit pop, full;
    if (r || c) begin
      past.delete(); mq.delete(); m_ovf = 0; m_skw = 0;
      return;
    end
    // lane j of the aligned vector is what lane j received N-1-j cycles ago
    for (int j = 0; j < N; j++) begin
      int dl = N-1-j;
      av[j] = 0; ap[j] = '0;
      if (dl == 0) begin av[j] = v[j]; ap[j] = p[j]; end
      else if (past.size() >= dl) begin av[j] = past[dl-1].v[j]; ap[j] = past[dl-1].p[j]; end
      if (relu_en && ap[j][31]) ap[j] = '0;
`ifndef PSUM_RELU_EN
      ap[j] = av[j] ? ap[j] : '0;
`endif
    end
    pop  = (mq.size() != 0) && rdy;
    full = (mq.size() == D);
    if ((|av) && !(&av)) m_skw = 1;
    if ((&av) && full && !pop) m_ovf = 1;
    if (pop) void'(mq.pop_front());
    if ((&av) && (!full || pop)) mq.push_back(ap);
    s.v = v; s.p = p;
    past.push_front(s);
    if (past.size() > N) void'(past.pop_back());
  endtask

  task automatic step(input logic r, input logic c, input logic [N-1:0] v,
                      input logic [N-1:0][31:0] p, input logic rdy, input bit do_chk);
    rst = r; clear = c; col_valid_in = v; col_psum_in = p; out_ready = rdy;
    if (do_chk) compare_all();
    @(posedge clk);
    model_update(r, c, v, p, rdy);
    #1;
  endtask

  // per-cycle lane schedule for skewed vectors
  logic [N-1:0]       sv [SL];
  logic [N-1:0][31:0] sp [SL];

  task automatic clr_sched();
    for (int i = 0; i < SL; i++) begin sv[i] = '0; sp[i] = '0; end
  endtask

  task automatic add_vec(input int t, input logic [31:0] base, input logic [N-1:0] drop);
    for (int j = 0; j < N; j++) begin
      sv[t+j][j] = !drop[j];
      sp[t+j][j] = base + 32'(j);
    end
  endtask

  task automatic play(input int ncyc, input logic [63:0] rdy_mask, input int rst_at);
    for (int c = 0; c < ncyc; c++) step(c == rst_at, 0, sv[c], sp[c], rdy_mask[c], 1);
  endtask

  task automatic do_clear();
    step(0, 1, '0, '0, 0, 1);
  endtask

  typedef struct {
    logic [N-1:0] v; logic [N-1:0][31:0] p;
    logic e_vld; logic [2:0] e_cnt; logic [31:0] e_l0, e_l3;
  } row_t;
  row_t tbl[12];

  initial begin
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < N; j++) begin
        tbl[k].v[j] = (k == 5 + j);
        tbl[k].p[j] = (k == 5 + j) ? 32'(10 + j) : 32'd0;
      end
      tbl[k].e_vld = (k == 9);
      tbl[k].e_cnt = (k == 9) ? 3'd1 : 3'd0;
      tbl[k].e_l0  = (k == 9) ? 32'd10 : 32'd0;
      tbl[k].e_l3  = (k == 9) ? 32'd13 : 32'd0;
    end

    step(1, 0, '0, '0, 0, 0);
    step(1, 0, '0, '0, 0, 0);

    // single aligned vector, latency and reset state from cycle 0
    for (int k = 0; k < 12; k++) begin
      check("tbl_vld", out_valid, tbl[k].e_vld);
      check("tbl_cnt", vec_count, tbl[k].e_cnt);
      check("tbl_l0",  out_data[0], tbl[k].e_l0);
      check("tbl_l3",  out_data[3], tbl[k].e_l3);
      step(0, 0, tbl[k].v, tbl[k].p, 1, 1);
    end

    // five back-to-back vectors, no drain
    do_clear(); clr_sched();
    for (int v = 0; v < 5; v++) add_vec(v, 32'(100 * (v + 1)), '0);
    play(12, 64'd0, -1);
    check("ovf_cnt",  vec_count, 3'd4);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_head", out_data[0], 32'd100);

    do_clear();
    check("clr_ovf", overflow, 1'b0);
    check("clr_cnt", vec_count, 3'd0);

    // full FIFO with simultaneous pop when the fifth vector aligns
    clr_sched();
    for (int v = 0; v < 5; v++) add_vec(v, 32'(100 * (v + 1)), '0);
    play(10, 64'd1 << 7, -1);
    check("fp_cnt",  vec_count, 3'd4);
    check("fp_ovf",  overflow, 1'b0);
    check("fp_head", out_data[0], 32'd200);
    for (int k = 0; k < 4; k++) begin
      check("fp_order", out_data[0], 32'(100 * (k + 2)));
      step(0, 0, '0, '0, 1, 1);
    end
    check("fp_empty", out_valid, 1'b0);

    // lane 2 suppressed
    do_clear(); clr_sched();
    add_vec(0, 32'd500, 4'b0100);
    play(8, '1, -1);
    check("skw_flag", skew_err, 1'b1);
    check("skw_cnt",  vec_count, 3'd0);
    check("skw_vld",  out_valid, 1'b0);

    // reset with two buffered and one in flight
    do_clear(); clr_sched();
    for (int v = 0; v < 3; v++) add_vec(v, 32'(700 + 10 * v), '0);
    play(5, 64'd0, -1);
    check("pre_rst_cnt", vec_count, 3'd2);
    for (int c = 5; c < 12; c++) step(c == 5, 0, sv[c], sp[c], 0, 1);
    check("rst_vld", out_valid, 1'b0);
    check("rst_cnt", vec_count, 3'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_skw", skew_err, 1'b0);

`ifdef PSUM_RELU_EN
    for (int pass = 0; pass < 2; pass++) begin
      logic [N-1:0][31:0] vals, expv;
      vals = {32'd0, -32'sd1, 32'd7, -32'sd5};
      expv = pass == 0 ? {32'd0, 32'd0, 32'd7, 32'd0} : vals;
      relu_en = (pass == 0);
      do_clear(); clr_sched();
      for (int j = 0; j < N; j++) begin sv[j][j] = 1; sp[j][j] = vals[j]; end
      play(6, 64'd0, -1);
      check("relu", out_data, expv);
    end
    relu_en = 0;
`endif

    // random traffic
    do_clear(); clr_sched();
    for (int c = 0; c < 480; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [N-1:0] drop;
        drop = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
        add_vec(c, $urandom, drop);
      end
`ifdef PSUM_RELU_EN
      relu_en = $urandom_range(0, 1);
`endif
      step(0, $urandom_range(0, 99) == 0, sv[c], sp[c], $urandom_range(0, 1), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/psum_deskew_collector.md
PSUM_DESKEW_COLLECTOR -- requirements
Module: psum_deskew_collector

Interface
REQ-001 SHALL have parameter N_COLS, default 4, meaning number of systolic-array columns drained (>=2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning aligned-vector FIFO entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port clear  input  1  synchronous flush of delay lines, FIFO and sticky flags.
REQ-006 SHALL have port col_psum_in  input  N_COLS*32  signed psum from the bottom PE of each column; lane j is bits [32j+31:32j].
REQ-007 SHALL have port col_valid_in  input  N_COLS  per-column psum valid; bit j qualifies lane j.
REQ-008 SHALL have port out_data  output  N_COLS*32  aligned row vector at FIFO head, same lane packing.
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid is also high.
REQ-011 SHALL have port vec_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-012 SHALL have port overflow  output  1  sticky: an aligned vector was dropped.
REQ-013 SHALL have port skew_err  output  1  sticky: aligned valids disagreed across lanes.

Function
REQ-014 Lane j SHALL pass through a registered delay line of N_COLS-1-j stages (lane N_COLS-1 zero stages), carrying psum and valid together.
REQ-015 Invalid samples SHALL enter delay lines as psum 0, valid 0.
REQ-016 A vector whose lane-0 sample arrives in cycle t with lane j arriving in cycle t+j SHALL appear aligned in cycle t+N_COLS-1.
REQ-017 When all aligned valids are 1, the aligned vector SHALL be pushed into the FIFO at the end of that cycle.
REQ-018 When aligned valids are mixed (some 1, some 0), skew_err SHALL set, and no push SHALL occur.
REQ-019 With FIFO empty, out_valid SHALL rise in cycle t+N_COLS (latency N_COLS from lane-0 arrival).
REQ-020 A pop SHALL occur on any cycle with out_valid and out_ready both high; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 A push while full without a simultaneous pop SHALL drop the vector, set overflow, and leave FIFO contents unchanged.
REQ-022 A push while full with a simultaneous pop SHALL be accepted, vec_count unchanged.
REQ-023 A push and pop in the same cycle SHALL leave vec_count unchanged; a push into an empty FIFO SHALL NOT bypass to out_data in the same cycle.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 The block SHALL never stall the array; there is no upstream backpressure.
REQ-026 clear SHALL take priority over push/pop in the same cycle and produce the reset state next cycle.
REQ-027 Psum values SHALL pass bit-exact, 32-bit signed, with no arithmetic except REQ-031.

Reset
REQ-028 On rst, the block SHALL zero all delay-line data and valids, FIFO pointers, vec_count, out_valid, overflow and skew_err, and out_data SHALL read 0.
REQ-029 rst asserted mid-operation SHALL discard in-flight and buffered vectors.
REQ-030 The first post-reset push SHALL occur no earlier than N_COLS-1 cycles after rst deasserts.

Configuration
REQ-031 With PSUM_RELU_EN defined:
- a 1-bit input relu_en SHALL exist;
- when relu_en=1 at the push cycle, each negative lane SHALL be written as 0.
Without PSUM_RELU_EN:
- relu_en SHALL be absent;
- data SHALL pass unchanged.

Verification (N_COLS=4, FIFO_DEPTH=4)
REQ-032 Lane j valid with psum 10+j in cycle 5+j, out_ready=1 -> out_valid in cycle 9 only, lanes {10,11,12,13}, vec_count back to 0.
REQ-033 Five skewed vectors back-to-back, out_ready=0 -> four buffered, vec_count=4, fifth dropped, overflow=1, FIFO head = first vector.
REQ-034 FIFO full, fifth vector aligned in a cycle with out_ready=1 -> accepted, overflow=0, vec_count stays 4, order preserved.
REQ-035 Lane 2 valid suppressed in one skewed vector -> skew_err=1, no push, vec_count unchanged.
REQ-036 rst for 1 cycle while 2 vectors are buffered and 1 is in flight -> out_valid=0, vec_count=0, flags 0, and no late output from the in-flight vector.
REQ-037 PSUM_RELU_EN defined, relu_en=1, psums {-5,7,-1,0} -> out_data {0,7,0,0}; with relu_en=0 -> {-5,7,-1,0}.
